// File: rtl/dsm_pkg.sv
// Shared constants and arithmetic helpers for the multi-channel delta-sigma DAC.
// Feedback magnitude, saturation, legal loop orders and dither LFSR constants.
package dsm_pkg;

  localparam int ORDER_1 = 1;
  localparam int ORDER_2 = 2;

  // Galois form of x^16+x^14+x^13+x^11+1, shifting right
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  function automatic logic signed [63:0] FB_MAG(input int w);
    return 64'sd1 <<< (w - 1);
  endfunction

  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int aw);
    logic signed [63:0] mx, mn;
    mx = (64'sd1 <<< (aw - 1)) - 64'sd1;
    mn = -(64'sd1 <<< (aw - 1));
    if (v > mx) return mx;
    if (v < mn) return mn;
    return v;
  endfunction

endpackage

// File: rtl/dsm_mod_core.sv
// One channel of the delta-sigma loop: sample register, 1st/2nd-order saturating
// integrators and the output bit. Optional dither under DSM_DITHER_EN.
module dsm_mod_core
  import dsm_pkg::*;
#(
`ifdef DSM_DITHER_EN
  parameter logic [15:0] SEED = LFSR_SEED,
`endif
  parameter int DW    = 16,
  parameter int AW    = DW + 4,
  parameter int ORDER = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic                 i_load,
  input  logic signed [DW-1:0] i_x,
  output logic                 o_bit
);

  logic signed [DW-1:0] x_q, x_d;
  logic signed [AW-1:0] a1_q, a1_d, a2_q, a2_d;
  logic                 bit_q, bit_d;
  logic signed [63:0]   fb, s1, s2;
  logic        [AW-1:0] q;

  // Second integrator consumes the first integrator's pre-update value
  always_comb begin
    fb   = bit_q ? FB_MAG(DW) : -FB_MAG(DW);
    s1   = 64'(a1_q) + 64'(x_q) - fb;
    s2   = 64'(a2_q) + 64'(a1_q) - (fb <<< 1);
    a1_d = AW'(sat(s1, AW));
    a2_d = AW'(sat(s2, AW));
    x_d  = i_load ? i_x : x_q;
    q    = (ORDER == ORDER_2) ? a2_d : a1_d;
  end

`ifdef DSM_DITHER_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic [AW:0] qd;

  // Dither perturbs only the quantiser decision, never the integrators
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    qd     = {q[AW-1], q} + {{(AW-1){lfsr_q[1]}}, lfsr_q[1:0]};
    bit_d  = ~qd[AW];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)     lfsr_q <= SEED;
    else if (i_en) lfsr_q <= lfsr_d;
  end
`else
  assign bit_d = ~q[AW-1];
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      x_q   <= '0;
      a1_q  <= '0;
      a2_q  <= '0;
      bit_q <= 1'b0;
    end else begin
      x_q <= x_d;
      if (i_en) begin
        a1_q  <= a1_d;
        a2_q  <= a2_d;
        bit_q <= bit_d;
      end
    end
  end

  assign o_bit = bit_q;

endmodule

// File: rtl/dsm_dac_mc.sv
// Multi-channel delta-sigma DAC: sample holding register with valid/ready, OSR
// load-point counter, strobes, and N_CH loop cores. Optional dither: DSM_DITHER_EN.
module dsm_dac_mc
  import dsm_pkg::*;
#(
  parameter int N_CH       = 2,
  parameter int DATA_WIDTH = 16,
  parameter int ORDER      = 2,
  parameter int OSR        = 64,
  parameter int ACC_WIDTH  = DATA_WIDTH + 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_en,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [N_CH*DATA_WIDTH-1:0] i_data,
  output logic                       o_sample_stb,
  output logic                       o_underrun,
  output logic [N_CH-1:0]            o_bits
);

  localparam int CW = $clog2(OSR);

  if (!(ORDER == ORDER_1 || ORDER == ORDER_2)) begin : g_bad_order
    $error("dsm_dac_mc: ORDER must be 1 or 2");
  end
  if (OSR < 2) begin : g_bad_osr
    $error("dsm_dac_mc: OSR must be >= 2");
  end

  logic [CW-1:0]              osr_cnt_q, osr_cnt_d;
  logic [N_CH*DATA_WIDTH-1:0] hold_q, hold_d;
  logic                       hold_full_q, hold_full_d;
  logic                       stb_q, stb_d, und_q, und_d;
  logic                       load_pt, unload, xfer;

  // A transfer needs an empty hold and an unload needs a full one, so they never overlap
  always_comb begin
    load_pt     = i_en && (osr_cnt_q == CW'(OSR - 1));
    unload      = load_pt && hold_full_q;
    xfer        = i_valid && !hold_full_q;
    osr_cnt_d   = osr_cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    stb_d       = unload;
    und_d       = load_pt && !hold_full_q;
    if (i_en) osr_cnt_d = load_pt ? '0 : osr_cnt_q + CW'(1);
    if (unload) hold_full_d = 1'b0;
    if (xfer) begin
      hold_d      = i_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      osr_cnt_q   <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      stb_q       <= 1'b0;
      und_q       <= 1'b0;
    end else begin
      osr_cnt_q   <= osr_cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      stb_q       <= stb_d;
      und_q       <= und_d;
    end
  end

  assign o_ready      = ~hold_full_q;
  assign o_sample_stb = stb_q;
  assign o_underrun   = und_q;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    dsm_mod_core #(
`ifdef DSM_DITHER_EN
      .SEED  (LFSR_SEED ^ 16'(k)),
`endif
      .DW    (DATA_WIDTH),
      .AW    (ACC_WIDTH),
      .ORDER (ORDER)
    ) u_core (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_en   (i_en),
      .i_load (unload),
      .i_x    (hold_q[k*DATA_WIDTH +: DATA_WIDTH]),
      .o_bit  (o_bits[k])
    );
  end

endmodule

// File: tb/tb_dsm_dac_mc.sv
// Self-checking bench for dsm_dac_mc: three instances (1st order OSR 64, 2nd order
// OSR 64, 2nd order OSR 4) exercised by per-feature tasks with scoreboard queues.
module tb_dsm_dac_mc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        en1, v1, rdy1, stb1, und1;
  logic        en2, v2, rdy2, stb2, und2;
  logic        en3, v3, rdy3, stb3, und3;
  logic [31:0] d1, d2, d3;
  logic [1:0]  b1, b2, b3;

  dsm_dac_mc #(.N_CH(2), .DATA_WIDTH(16), .ORDER(1), .OSR(64), .ACC_WIDTH(20)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_en(en1), .i_valid(v1), .o_ready(rdy1), .i_data(d1),
    .o_sample_stb(stb1), .o_underrun(und1), .o_bits(b1));
  dsm_dac_mc #(.N_CH(2), .DATA_WIDTH(16), .ORDER(2), .OSR(64), .ACC_WIDTH(20)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_en(en2), .i_valid(v2), .o_ready(rdy2), .i_data(d2),
    .o_sample_stb(stb2), .o_underrun(und2), .o_bits(b2));
  dsm_dac_mc #(.N_CH(2), .DATA_WIDTH(16), .ORDER(2), .OSR(4), .ACC_WIDTH(20)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_en(en3), .i_valid(v3), .o_ready(rdy3), .i_data(d3),
    .o_sample_stb(stb3), .o_underrun(und3), .o_bits(b3));

  typedef struct { int cyc; int kind; } ev_t;  // kind 1 = sample strobe, 2 = underrun
  ev_t ev_q[$];
  int  exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit en_on);
    rst = 1'b1;
    {en1, en2, en3} = {3{en_on}};
    {v1, v2, v3} = 3'b000;
    d1 = '0; d2 = '0; d3 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_stb(input int which, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      case (which)
        1:       seen = stb1;
        2:       seen = stb2;
        default: seen = stb3;
      endcase
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: sample strobe timeout, got none, required one within 200 cycles", tag);
    end
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    checks++;
    if ({b1, b2, b3} !== 6'b0) begin
      errors++; $display("FAIL reset_bits: got %b required 000000", {b1, b2, b3});
    end
    checks++;
    if ({rdy1, rdy2, rdy3} !== 3'b111) begin
      errors++; $display("FAIL reset_ready: got %b required 111", {rdy1, rdy2, rdy3});
    end
    checks++;
    if ({stb1, stb2, stb3, und1, und2, und3} !== 6'b0) begin
      errors++; $display("FAIL reset_strobes: got %b required 000000",
                         {stb1, stb2, stb3, und1, und2, und3});
    end
  endtask

  // x = 0 from reset: first step lifts from -FS feedback, then strict alternation
  task automatic test_zero_input();
    logic [1:0] exp_b;
    do_reset(1'b1);
    for (int k = 0; k < 16; k++) begin
      tick();
      exp_b = (k == 0 || (k % 2) == 1) ? 2'b11 : 2'b00;
      checks++;
      if (b1 !== exp_b) begin
        errors++; $display("FAIL zero_input step %0d: got %b required %b", k, b1, exp_b);
      end
    end
  endtask

  task automatic test_density(input string tag, input logic [15:0] c0, input logic [15:0] c1,
                              input int e0, input int e1);
    int n0, n1, e;
    do_reset(1'b1);
    exp_q.push_back(e0);
    exp_q.push_back(e1);
    v1 = 1'b1; d1 = {c1, c0};
    tick();
    v1 = 1'b0;
    wait_stb(1, tag);
    checks++;
    if (rdy1 !== 1'b1) begin
      errors++; $display("FAIL %s ready_after_load: got %b required 1", tag, rdy1);
    end
    repeat (64) tick();
    n0 = 0; n1 = 0;
    repeat (64) begin
      tick();
      n0 += int'(b1[0]);
      n1 += int'(b1[1]);
    end
    e = exp_q.pop_front();
    checks++;
    if (n0 !== e) begin
      errors++; $display("FAIL %s ch0_density: got %0d/64 required %0d/64", tag, n0, e);
    end
    e = exp_q.pop_front();
    checks++;
    if (n1 !== e) begin
      errors++; $display("FAIL %s ch1_density: got %0d/64 required %0d/64", tag, n1, e);
    end
  endtask

  task automatic test_saturation();
    int n = 0;
    do_reset(1'b1);
    v2 = 1'b1; d2 = 32'h8000_8000;
    tick();
    v2 = 1'b0;
    wait_stb(2, "saturation");
    repeat (8) tick();
    repeat (64) begin
      tick();
      if (b2 !== 2'b00) n++;
    end
    checks++;
    if (n !== 0) begin
      errors++; $display("FAIL saturation: got %0d nonzero bit cycles required 0", n);
    end
  endtask

  // Reference model of the load-point schedule; predicted events go to ev_q
  task automatic test_underrun();
    int  cnt_m = 0;
    bit  hold_m = 1'b0, sent2 = 1'b0, xfer, lp;
    ev_t ev;
    do_reset(1'b1);
    ev_q.delete();
    for (int c = 0; c < 48; c++) begin
      en3 = !(c >= 13 && c < 19);
      v3  = (c == 2) || (c >= 24 && !sent2 && cnt_m == 3 && en3);
      d3  = (c == 2) ? 32'h1234_4321 : 32'h0F0F_F0F0;
      xfer = v3 && !hold_m;
      if (xfer && c >= 24) sent2 = 1'b1;
      lp = en3 && cnt_m == 3;
      if (lp) ev_q.push_back('{c + 1, hold_m ? 1 : 2});
      if (lp && hold_m) hold_m = 1'b0;
      if (xfer) hold_m = 1'b1;
      if (en3) cnt_m = (cnt_m + 1) % 4;
      tick();
      v3 = 1'b0;
      checks++;
      if (rdy3 !== !hold_m) begin
        errors++; $display("FAIL underrun ready cycle %0d: got %b required %b", c + 1, rdy3, !hold_m);
      end
      if (stb3 || und3) begin
        checks++;
        if (ev_q.size() == 0) begin
          errors++; $display("FAIL underrun unexpected pulse cycle %0d: got stb=%b und=%b required none",
                             c + 1, stb3, und3);
        end else begin
          ev = ev_q.pop_front();
          if (ev.cyc !== c + 1 || (stb3 && und3) || (ev.kind == 1) !== stb3) begin
            errors++; $display("FAIL underrun event cycle %0d: got stb=%b und=%b required kind %0d at cycle %0d",
                               c + 1, stb3, und3, ev.kind, ev.cyc);
          end
        end
      end
      if (ev_q.size() > 0 && ev_q[0].cyc <= c + 1) begin
        ev = ev_q.pop_front();
        checks++; errors++;
        $display("FAIL underrun missed event: got no pulse required kind %0d at cycle %0d", ev.kind, ev.cyc);
      end
    end
    checks++;
    if (ev_q.size() != 0) begin
      errors++; $display("FAIL underrun leftover: got %0d pending required 0", ev_q.size());
    end
    en3 = 1'b0;
  endtask

  task automatic test_hold_reset();
    int n = 0;
    bit got_one = 1'b0;
    do_reset(1'b0);
    v3 = 1'b1; d3 = 32'h4000_4000;
    tick();
    d3 = 32'hC000_C000;
    repeat (5) begin
      tick();
      checks++;
      if (rdy3 !== 1'b0) begin
        errors++; $display("FAIL hold_full_ready: got %b required 0", rdy3);
      end
    end
    v3 = 1'b0;
    en3 = 1'b1;
    wait_stb(3, "hold_no_overwrite");
    repeat (16) tick();
    repeat (64) begin
      tick();
      n += int'(b3[0]);
    end
    checks++;
    if (n < 44 || n > 52) begin
      errors++; $display("FAIL hold_no_overwrite density: got %0d/64 required 44..52", n);
    end
    for (int i = 0; i < 20 && !got_one; i++) begin
      tick();
      got_one = (b3 != 2'b00);
    end
    checks++;
    if (!got_one) begin
      errors++; $display("FAIL midreset_setup: got bits 00 required a nonzero bit within 20 cycles");
    end
    en3 = 1'b0;
    v3 = 1'b1; d3 = 32'h2000_2000;
    tick();
    v3 = 1'b0;
    checks++;
    if (rdy3 !== 1'b0) begin
      errors++; $display("FAIL midreset_hold_full: got ready %b required 0", rdy3);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (b3 !== 2'b00 || rdy3 !== 1'b1 || stb3 !== 1'b0 || und3 !== 1'b0) begin
      errors++; $display("FAIL async_reset: got bits %b ready %b stb %b und %b required 00 1 0 0",
                         b3, rdy3, stb3, und3);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    checks++;
    if (rdy3 !== 1'b1) begin
      errors++; $display("FAIL reset_discard_hold: got ready %b required 1", rdy3);
    end
  endtask

  initial begin
    test_reset();
    test_zero_input();
    test_density("density_half", 16'h4000, 16'h4000, 48, 48);
    test_density("density_pm_quarter", 16'h2000, 16'hE000, 40, 24);
    test_saturation();
    test_underrun();
    test_hold_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
